mealy_inverse_deser: RTL and testbench
======================================

Name: mealy_inverse_deser

Overview:
Receive-side companion to the team's 4-state Mealy sequence encoder. It consumes the encoder's serial output bit y, one bit per handshake beat. It runs an identical copy of the encoder state machine to recover the original input bit x, then packs the recovered bits LSB-first into WIDTH-bit words. Words are presented on a valid/ready output port. It sits directly after the encoder's serial link, or after any stage that carries its y stream.

Parameters:
WIDTH, 8, recovered bits per output word (2..32)

Ports:
clock  input  1  system clock, all flops rising-edge
reset  input  1  asynchronous, active-low; clears all state
sync  input  1  synchronous resync: force tracker to state A, discard partial word
y_in  input  1  encoded serial bit
y_valid  input  1  y_in holds a beat
y_ready  output  1  beat accepted when y_valid & y_ready
data_out  output  WIDTH  recovered word, bit 0 = first decoded bit
data_valid  output  1  data_out holds an unread word
data_ready  input  1  consumer takes word when data_valid & data_ready
dec_state  output  2  current tracker state (debug)

Behaviour:
- Reset (reset=0, asynchronous):
  - tracker state = A (2'b00); bit_cnt = 0; shift register = 0.
  - data_out = 0; data_valid = 0; dec_state = 2'b00.
  - y_ready = 1 once reset is released.
- State encoding: A=00, B=01, C=10, D=11. Parity p = state[1]^state[0] (A,D -> 0; B,C -> 1).
- Decode is combinational within the beat: x = ~(y_in ^ p). This is the exact inverse of the encoder's y = ~(p ^ x).
- Next state on an accepted beat, using the decoded x:
  - A: x=0 -> B, x=1 -> C
  - B: x=0 -> C, x=1 -> D
  - C: x=0 -> B, x=1 -> D
  - D: x=0 -> C, x=1 -> A
- No accepted beat: state, bit_cnt and the shift register hold.
- Packing:
  - Each accepted beat writes x into bit position bit_cnt, then bit_cnt increments.
  - On the beat with bit_cnt==WIDTH-1, the completed word (including this x) loads into data_out, data_valid<=1 and bit_cnt<=0.
  - Latency: data_valid rises on the clock edge that accepts the WIDTH-th bit.
- Output handshake:
  - data_valid & data_ready with no completing beat: data_valid<=0; data_out holds its value.
  - data_valid & data_ready on the same edge as a completing beat: new word loads and data_valid stays 1. No gap, no loss.
- Backpressure: y_ready = ~sync & ~(bit_cnt==WIDTH-1 & data_valid & ~data_ready).
  - y_ready depends combinationally on data_ready and sync; there is no combinational path from y_valid.
  - Beats before the last bit of a word are never stalled.
- sync (synchronous, priority over beats):
  - state<=A, bit_cnt<=0, shift<=0. y_ready is 0 that cycle, so no beat is accepted.
  - data_out and data_valid are unaffected; a pending word is still delivered.
- Reset asserted mid-word: partial word lost, all outputs return to reset values immediately.
- dec_state = registered tracker state.
- No X propagation: y_in is ignored when y_valid=0.

Decomposition:
- Package mealy_seq_pkg holds:
  - state constants ST_A..ST_D;
  - function parity(state);
  - function next_state(state, x);
  - function decode_x(state, y).
- The same package is reused by the encoder side.
- Sub-module mealy_inverse_core: contains the state register plus decode. Inputs: clock, reset, sync, y_in, step. Outputs: x, state.
- Top level adds bit counter, shift register, output register and handshake.

Test Plan:
- Reset then WIDTH=4, beats y=0,0,1,0 with data_ready=1 -> x=1,0,1,1; data_out=4'hD, data_valid=1 on the 4th accepting edge; dec_state sequence C,B,D,A.
- WIDTH=4, beats y=1,0,0,0 -> x=0,0,0,0; data_out=4'h0; dec_state B,C,B,C.
- data_ready=0, word 1 pending, feed 3 more beats of word 2 -> y_ready=0 on the 4th bit. Raise data_ready -> word 1 read, y_ready=1 same cycle, word 2 loads next edge with data_valid held 1.
- Random 1000-bit x stream through a reference encoder model into the DUT with random y_valid/data_ready gaps -> every word equals the packed x bits; no loss or duplication.
- sync pulse after 2 beats of a word -> dec_state=A next cycle, y_ready=0 during sync. The next 4 beats (y=0,0,1,0) yield 4'hD; the earlier pending word is unchanged.
- Assert reset mid-word with data_valid=1 -> data_valid=0, data_out=0, dec_state=00 asynchronously; y_ready=1 after release.

Source files
------------

// File: rtl/mealy_seq_pkg.sv
// Shared definitions for the 4-state Mealy sequence encoder and its inverse.
// Both sides import this package so that they use the same state machine.
package mealy_seq_pkg;

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b10,
    ST_D = 2'b11
  } state_e;

  // A and D have even parity; B and C have odd parity.
  function automatic logic parity(input state_e s);
    return s[1] ^ s[0];
  endfunction

  function automatic state_e next_state(input state_e s, input logic x);
    state_e n;
    n = ST_A;
    case (s)
      ST_A: n = x ? ST_C : ST_B;
      ST_B: n = x ? ST_D : ST_C;
      ST_C: n = x ? ST_D : ST_B;
      ST_D: n = x ? ST_A : ST_C;
      default: n = ST_A;
    endcase
    return n;
  endfunction

  function automatic logic encode_y(input state_e s, input logic x);
    return ~(parity(s) ^ x);
  endfunction

  function automatic logic decode_x(input state_e s, input logic y);
    return ~(y ^ parity(s));
  endfunction

endpackage

// File: rtl/mealy_inverse_core.sv
// Tracker that mirrors the encoder state machine; it recovers x from each
// received y bit and advances only when the top level accepts a beat.
module mealy_inverse_core
  import mealy_seq_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   sync,
  input  logic   y_in,
  input  logic   step,
  output logic   x,
  output state_e state
);

  state_e state_q, state_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    x       = decode_x(state_q, y_in);
    if (sync)      state_d = ST_A;
    else if (step) state_d = next_state(state_q, x);
  end

  assign state = state_q;

endmodule

// File: rtl/mealy_inverse_deser.sv
// Decodes the Mealy encoder's serial y stream and packs recovered bits
// LSB-first into WIDTH-bit words on a valid/ready output port.
module mealy_inverse_deser
  import mealy_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sync,
  input  logic             y_in,
  input  logic             y_valid,
  output logic             y_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [1:0]       dec_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             step;
  logic             x_bit;
  state_e           core_state;

  // Both ports transfer on the rising edge where valid & ready are high.
  // y_ready never looks at y_valid; it drops only during sync or when the
  // last bit of a word would overwrite an unread word.
  assign last_bit = (bit_cnt_q == LAST);
  assign y_ready  = ~sync & ~(last_bit & valid_q & ~data_ready);
  assign step     = y_valid & y_ready;

  mealy_inverse_core u_core (
    .clock (clock),
    .reset (reset),
    .sync  (sync),
    .y_in  (y_in),
    .step  (step),
    .x     (x_bit),
    .state (core_state)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    data_d         = data_q;
    valid_d        = valid_q;
    word           = shift_q;
    word[bit_cnt_q] = x_bit;

    if (valid_q && data_ready) valid_d = 1'b0;

    if (sync) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (step) begin
      if (last_bit) begin
        // Completing beat wins over a same-cycle read: the word is replaced.
        data_d    = word;
        valid_d   = 1'b1;
        shift_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shift_d   = word;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign dec_state  = core_state;

endmodule

// File: tb/tb_mealy_inverse_deser.sv
// Bench for mealy_inverse_deser at WIDTH=4: directed decode, backpressure,
// sync and reset cases plus a random stream from an independent encoder model.
module tb_mealy_inverse_deser;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         sync;
  logic         y_in;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic [1:0]   dec_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   enc_state;
  logic [W-1:0] acc_word;
  int           acc_cnt;
  bit           rand_ready = 1'b0;

  logic [1:0] st1 [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
  logic [1:0] st2 [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
  logic [3:0] ys;

  always #5 clock = ~clock;

  mealy_inverse_deser #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .sync       (sync),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dec_state  (dec_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc_next(input logic [1:0] s, input logic x);
    logic [1:0] n;
    case ({s, x})
      3'b000: n = 2'b01;
      3'b001: n = 2'b10;
      3'b010: n = 2'b10;
      3'b011: n = 2'b11;
      3'b100: n = 2'b01;
      3'b101: n = 2'b11;
      3'b110: n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic logic enc_y(input logic [1:0] s, input logic x);
    return ~((s[1] ^ s[0]) ^ x);
  endfunction

  task automatic model_reset();
    enc_state = 2'b00;
    acc_word  = '0;
    acc_cnt   = 0;
  endtask

  task automatic model_accept(input logic x);
    enc_state         = enc_next(enc_state, x);
    acc_word[acc_cnt] = x;
    acc_cnt++;
    if (acc_cnt == W) begin
      exp_q.push_back(acc_word);
      acc_word = '0;
      acc_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; sync = 1'b0; y_valid = 1'b0; y_in = 1'b0; data_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic drive_beat(input logic y, output bit ok);
    int n;
    n = 0;
    @(negedge clock);
    y_in = y; y_valid = 1'b1;
    #1;
    while (!y_ready && n < 100) begin
      @(negedge clock); #1; n++;
    end
    ok = y_ready;
    check("beat_accept", y_ready, 1);
    @(posedge clock); #1;
    y_valid = 1'b0;
    y_in = 1'($urandom_range(0, 1));
  endtask

  task automatic beat_x(input logic x);
    bit ok;
    drive_beat(enc_y(enc_state, x), ok);
    if (ok) model_accept(x);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock); n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Consumer side: random readiness while enabled.
  initial forever begin
    @(negedge clock);
    if (rand_ready) data_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: every transferred word is popped and compared.
  initial forever begin
    @(negedge clock); #1;
    if (reset === 1'b1 && data_valid && data_ready) begin
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("word", data_out, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic x;
    logic [W-1:0] pend;

    // Reset values
    do_reset();
    #1;
    check("rst_state", dec_state, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_ready", y_ready, 1);

    // y=0,0,1,0 -> x=1,0,1,1 -> 4'hD
    data_ready = 1'b1;
    exp_q.push_back(4'hD);
    ys = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      drive_beat(ys[i], ok);
      check("t1_state", dec_state, st1[i]);
      if (i == 2) check("t1_not_valid", data_valid, 0);
      if (i == 3) begin
        check("t1_valid", data_valid, 1);
        check("t1_data", data_out, 4'hD);
      end
    end
    drain("t1_drain");

    // y=1,0,0,0 -> x=0,0,0,0
    exp_q.push_back(4'h0);
    ys = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      drive_beat(ys[i], ok);
      check("t2_state", dec_state, st2[i]);
    end
    check("t2_data", data_out, 4'h0);
    drain("t2_drain");

    // Backpressure on the last bit of the second word
    do_reset();
    for (int i = 0; i < 7; i++) beat_x(1'($urandom_range(0, 1)));
    x = 1'($urandom_range(0, 1));
    @(negedge clock);
    y_in = enc_y(enc_state, x); y_valid = 1'b1;
    #1;
    check("bp_stall", y_ready, 0);
    @(negedge clock); #1;
    check("bp_stall2", y_ready, 0);
    @(negedge clock);
    data_ready = 1'b1;
    #1;
    check("bp_release", y_ready, 1);
    @(posedge clock); #1;
    model_accept(x);
    y_valid = 1'b0;
    check("bp_hold_valid", data_valid, 1);
    check("bp_word2", data_out, exp_q[exp_q.size()-1]);
    drain("bp_drain");

    // Random stream with gaps on both sides
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      beat_x(1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    @(negedge clock);
    data_ready = 1'b1;
    drain("rand_drain");

    // Sync after two beats with a pending word
    do_reset();
    for (int i = 0; i < 6; i++) beat_x(1'($urandom_range(0, 1)));
    pend = exp_q[0];
    @(negedge clock);
    sync = 1'b1;
    #1;
    check("sync_ready", y_ready, 0);
    @(posedge clock); #1;
    check("sync_state", dec_state, 0);
    check("sync_valid", data_valid, 1);
    check("sync_pend", data_out, pend);
    @(negedge clock);
    sync = 1'b0;
    data_ready = 1'b1;
    model_reset();
    exp_q.push_back(4'hD);
    ys = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      drive_beat(ys[i], ok);
      check("sync_t_state", dec_state, st1[i]);
    end
    drain("sync_drain");

    // Reset asserted mid-word with a word pending
    do_reset();
    for (int i = 0; i < 6; i++) beat_x(1'($urandom_range(0, 1)));
    check("mid_pre_valid", data_valid, 1);
    @(negedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("mid_valid", data_valid, 0);
    check("mid_data", data_out, 0);
    check("mid_state", dec_state, 0);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_ready", y_ready, 1);
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat_x(1'($urandom_range(0, 1)));
    drain("mid_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
